// File: rtl/mipi_csi_packet_decoder_if.sv
// ---------------------------------------------------------------------------
// mipi_csi_packet_decoder_if
//   Bundles the aligned-word input stream and the decoded outputs of the
//   CSI-2 packet decoder.
//   Ports / signals:
//     data_i, data_valid_i      aligned 32-bit word stream from the byte aligner
//     payload_o/_valid/_be/_last long-packet payload stream to the unpacker
//     frame_start_o, frame_end_o FS / FE markers (1-cycle pulses)
//     lsync_o                    line active from first to last payload word
//     frame_num_o                WC field of the most recent FS packet
//     line_count_o               accepted lines since the last FS
//     pkt_err_o                  burst ended before WC bytes arrived
//   Modports: slave = decoder view, master = word source / sink view.
// ---------------------------------------------------------------------------
interface mipi_csi_packet_decoder_if #(
    parameter int LINE_CNT_W = 12
);
    logic [31:0]           data_i;
    logic                  data_valid_i;
    logic [31:0]           payload_o;
    logic                  payload_valid_o;
    logic [3:0]            payload_be_o;
    logic                  payload_last_o;
    logic                  frame_start_o;
    logic                  frame_end_o;
    logic                  lsync_o;
    logic [15:0]           frame_num_o;
    logic [LINE_CNT_W-1:0] line_count_o;
    logic                  pkt_err_o;

    modport slave (
        input  data_i, data_valid_i,
        output payload_o, payload_valid_o, payload_be_o, payload_last_o,
        output frame_start_o, frame_end_o, lsync_o, frame_num_o,
        output line_count_o, pkt_err_o
    );

    modport master (
        output data_i, data_valid_i,
        input  payload_o, payload_valid_o, payload_be_o, payload_last_o,
        input  frame_start_o, frame_end_o, lsync_o, frame_num_o,
        input  line_count_o, pkt_err_o
    );
endinterface

// File: rtl/mipi_csi_packet_decoder.sv
// ---------------------------------------------------------------------------
// mipi_csi_packet_decoder
//   Parses CSI-2 packet headers from aligned 32-bit words (sync byte already
//   stripped), emits frame markers, and forwards long-packet payload of the
//   accepted data type / virtual channel with byte enables and a per-frame
//   line counter. All outputs are registered (1-cycle latency from data_i).
//   Ports:
//     clk_i     byte clock, rising edge
//     reset_in  asynchronous reset, active-low
//     bus       mipi_csi_packet_decoder_if.slave (stream in, decoded out)
//   LINE_CNT_W must match the LINE_CNT_W of the connected interface.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   IDLE     | waiting for a burst; first valid word is the packet header
//   PAYLOAD  | forwarding long-packet payload words, counting down WC
//   WAIT_END | discarding trailer / padding / ignored packet until burst ends
// ---------------------------------------------------------------------------
module mipi_csi_packet_decoder #(
    parameter logic [5:0] ACCEPT_DT  = 6'h2B,
    parameter logic [1:0] ACCEPT_VC  = 2'd0,
    parameter int         LINE_CNT_W = 12
) (
    input  logic                          clk_i,
    input  logic                          reset_in,
    mipi_csi_packet_decoder_if.slave      bus
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] PAYLOAD  = 2'd1;
    localparam logic [1:0] WAIT_END = 2'd2;

    localparam logic [5:0] DT_FS        = 6'h00;
    localparam logic [5:0] DT_FE        = 6'h01;
    localparam logic [5:0] DT_SHORT_LIM = 6'h10;

    logic [1:0]            state_q;
    logic [15:0]           remaining_q;
    logic [31:0]           payload_q;
    logic                  payload_valid_q;
    logic [3:0]            payload_be_q;
    logic                  payload_last_q;
    logic                  frame_start_q;
    logic                  frame_end_q;
    logic                  lsync_q;
    logic [15:0]           frame_num_q;
    logic [LINE_CNT_W-1:0] line_count_q;
    logic                  pkt_err_q;

    logic [5:0]            hdr_dt;
    logic [1:0]            hdr_vc;
    logic [15:0]           hdr_wc;
    logic                  last_word;
    logic [3:0]            last_be;

    assign hdr_dt = bus.data_i[5:0];
    assign hdr_vc = bus.data_i[7:6];
    assign hdr_wc = {bus.data_i[23:16], bus.data_i[15:8]};

    // Final word of the packet carries the 1..4 bytes still owed.
    assign last_word = (remaining_q <= 16'd4);

    always_comb begin
        last_be = 4'b1111;
        case (remaining_q[2:0])
            3'd1:    last_be = 4'b0001;
            3'd2:    last_be = 4'b0011;
            3'd3:    last_be = 4'b0111;
            default: last_be = 4'b1111;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_in) begin
        if (!reset_in) begin
            state_q         <= IDLE;
            remaining_q     <= '0;
            payload_q       <= '0;
            payload_valid_q <= 1'b0;
            payload_be_q    <= '0;
            payload_last_q  <= 1'b0;
            frame_start_q   <= 1'b0;
            frame_end_q     <= 1'b0;
            lsync_q         <= 1'b0;
            frame_num_q     <= '0;
            line_count_q    <= '0;
            pkt_err_q       <= 1'b0;
        end else begin
            payload_valid_q <= 1'b0;
            payload_last_q  <= 1'b0;
            frame_start_q   <= 1'b0;
            frame_end_q     <= 1'b0;
            pkt_err_q       <= 1'b0;
            // lsync stays up through the last-word cycle, drops the next one.
            if (payload_last_q) begin
                lsync_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (bus.data_valid_i) begin
                        if (hdr_vc != ACCEPT_VC) begin
                            state_q <= WAIT_END;
                        end else if (hdr_dt == DT_FS) begin
                            frame_start_q <= 1'b1;
                            frame_num_q   <= hdr_wc;
                            line_count_q  <= '0;
                            state_q       <= WAIT_END;
                        end else if (hdr_dt == DT_FE) begin
                            frame_end_q <= 1'b1;
                            state_q     <= WAIT_END;
                        end else if (hdr_dt < DT_SHORT_LIM) begin
                            state_q <= WAIT_END;
                        end else if (hdr_dt == ACCEPT_DT && hdr_wc != 16'd0) begin
                            remaining_q <= hdr_wc;
                            state_q     <= PAYLOAD;
                        end else begin
                            state_q <= WAIT_END;
                        end
                    end
                end

                PAYLOAD: begin
                    if (bus.data_valid_i) begin
                        payload_q       <= bus.data_i;
                        payload_valid_q <= 1'b1;
                        lsync_q         <= 1'b1;
                        if (last_word) begin
                            payload_be_q   <= last_be;
                            payload_last_q <= 1'b1;
                            line_count_q   <= line_count_q + 1'b1;
                            remaining_q    <= '0;
                            state_q        <= WAIT_END;
                        end else begin
                            payload_be_q <= 4'b1111;
                            remaining_q  <= remaining_q - 16'd4;
                        end
                    end else begin
                        // Burst ended short: the line is abandoned, not counted.
                        pkt_err_q   <= 1'b1;
                        lsync_q     <= 1'b0;
                        remaining_q <= '0;
                        state_q     <= IDLE;
                    end
                end

                WAIT_END: begin
                    if (!bus.data_valid_i) begin
                        state_q <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.payload_o       = payload_q;
    assign bus.payload_valid_o = payload_valid_q;
    assign bus.payload_be_o    = payload_be_q;
    assign bus.payload_last_o  = payload_last_q;
    assign bus.frame_start_o   = frame_start_q;
    assign bus.frame_end_o     = frame_end_q;
    assign bus.lsync_o         = lsync_q;
    assign bus.frame_num_o     = frame_num_q;
    assign bus.line_count_o    = line_count_q;
    assign bus.pkt_err_o       = pkt_err_q;

endmodule

// File: tb/tb_mipi_csi_packet_decoder.sv
module tb_mipi_csi_packet_decoder;

    logic clk_i;
    logic reset_in;

    mipi_csi_packet_decoder_if #(.LINE_CNT_W(12)) bus ();

    mipi_csi_packet_decoder #(
        .ACCEPT_DT (6'h2B),
        .ACCEPT_VC (2'd0),
        .LINE_CNT_W(12)
    ) dut (
        .clk_i   (clk_i),
        .reset_in(reset_in),
        .bus     (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // {data, be, last}
    logic [36:0] sb[$];

    int valid_cnt, last_cnt, lsync_cnt, fs_cnt, fe_cnt, err_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        valid_cnt = 0; last_cnt = 0; lsync_cnt = 0;
        fs_cnt = 0; fe_cnt = 0; err_cnt = 0;
    endtask

    // Inputs change 1 time unit after the active edge.
    task automatic drive(input logic v, input logic [31:0] d);
        bus.data_valid_i = v;
        bus.data_i       = d;
        @(posedge clk_i);
        #1;
    endtask

    // Payload words of a long packet; nwords < full count truncates the line.
    task automatic send_payload(input int wc, input int nwords);
        logic [31:0] d;
        logic [3:0]  be;
        int          rem;
        for (int i = 0; i < nwords; i++) begin
            d   = $urandom;
            rem = wc - 4 * i;
            if (rem >= 4) be = 4'hF;
            else if (rem == 3) be = 4'h7;
            else if (rem == 2) be = 4'h3;
            else be = 4'h1;
            sb.push_back({d, be, (rem <= 4)});
            drive(1'b1, d);
        end
    endtask

    task automatic send_line(input int wc);
        drive(1'b1, {8'h00, 8'(wc >> 8), 8'(wc), 8'h2B});
        send_payload(wc, (wc + 3) / 4);
        drive(1'b1, 32'hC0C0_C0C0);
        drive(1'b0, 32'h0);
    endtask

    // Output monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk_i) begin
        if (reset_in) begin
            if (bus.lsync_o) lsync_cnt++;
            if (bus.frame_start_o) fs_cnt++;
            if (bus.frame_end_o) fe_cnt++;
            if (bus.pkt_err_o) err_cnt++;
            if (bus.payload_valid_o) begin
                logic [36:0] e;
                valid_cnt++;
                if (bus.payload_last_o) last_cnt++;
                checks++;
                assert (sb.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_payload observed=%0h expected=none", bus.payload_o);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("payload_data", bus.payload_o, e[36:5]);
                    check("payload_be", 32'(bus.payload_be_o), 32'(e[4:1]));
                    check("payload_last", 32'(bus.payload_last_o), 32'(e[0]));
                    check("lsync_during_payload", 32'(bus.lsync_o), 32'd1);
                end
            end
        end
    end

    initial begin
        reset_in         = 1'b0;
        bus.data_i       = '0;
        bus.data_valid_i = 1'b0;
        clear_counts();
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_payload_valid", 32'(bus.payload_valid_o), 32'd0);
        check("rst_frame_num", 32'(bus.frame_num_o), 32'd0);
        check("rst_line_count", 32'(bus.line_count_o), 32'd0);
        check("rst_lsync", 32'(bus.lsync_o), 32'd0);
        check("rst_fs", 32'(bus.frame_start_o), 32'd0);
        reset_in = 1'b1;
        drive(1'b0, 32'h0);

        // 1: frame start
        clear_counts();
        drive(1'b1, 32'h0000_0100);
        drive(1'b0, 32'h0);
        drive(1'b0, 32'h0);
        check("t1_fs_pulses", 32'(fs_cnt), 32'd1);
        check("t1_frame_num", 32'(bus.frame_num_o), 32'd1);
        check("t1_line_count", 32'(bus.line_count_o), 32'd0);

        // 2: full RAW10 line with 2 CRC words
        clear_counts();
        drive(1'b1, 32'h1A09_602B);
        send_payload(2400, 600);
        drive(1'b1, 32'hDEAD_BEEF);
        drive(1'b1, 32'hCAFE_F00D);
        drive(1'b0, 32'h0);
        drive(1'b0, 32'h0);
        check("t2_valid_cnt", 32'(valid_cnt), 32'd600);
        check("t2_last_cnt", 32'(last_cnt), 32'd1);
        check("t2_lsync_cycles", 32'(lsync_cnt), 32'd600);
        check("t2_line_count", 32'(bus.line_count_o), 32'd1);
        check("t2_sb_drained", 32'(sb.size()), 32'd0);

        // 3: WC=10 -> be F,F,3
        clear_counts();
        drive(1'b1, 32'h0000_0A2B);
        send_payload(10, 3);
        drive(1'b0, 32'h0);
        drive(1'b0, 32'h0);
        check("t3_valid_cnt", 32'(valid_cnt), 32'd3);
        check("t3_last_cnt", 32'(last_cnt), 32'd1);
        check("t3_line_count", 32'(bus.line_count_o), 32'd2);

        // 4: truncated line, then header right after a single idle cycle
        clear_counts();
        drive(1'b1, 32'h0009_602B);
        send_payload(2400, 100);
        drive(1'b0, 32'h0);
        check("t4_err_now", 32'(bus.pkt_err_o), 32'd1);
        check("t4_lsync_low", 32'(bus.lsync_o), 32'd0);
        drive(1'b1, 32'h0000_072B);
        send_payload(7, 2);
        drive(1'b0, 32'h0);
        drive(1'b0, 32'h0);
        check("t4_err_pulses", 32'(err_cnt), 32'd1);
        check("t4_valid_cnt", 32'(valid_cnt), 32'd102);
        check("t4_last_cnt", 32'(last_cnt), 32'd1);
        check("t4_line_count", 32'(bus.line_count_o), 32'd3);

        // 5: ignored packets, then FE
        clear_counts();
        drive(1'b1, 32'h0009_606B);
        drive(1'b1, 32'h1111_1111);
        drive(1'b1, 32'h2222_2222);
        drive(1'b0, 32'h0);
        drive(1'b1, 32'h0000_082A);
        drive(1'b1, 32'h3333_3333);
        drive(1'b1, 32'h4444_4444);
        drive(1'b0, 32'h0);
        drive(1'b1, 32'h0000_002B);
        drive(1'b1, 32'h5555_5555);
        drive(1'b0, 32'h0);
        drive(1'b1, 32'h0000_0508);
        drive(1'b0, 32'h0);
        drive(1'b1, 32'h0000_0040);
        drive(1'b0, 32'h0);
        check("t5_no_payload", 32'(valid_cnt), 32'd0);
        check("t5_no_fs", 32'(fs_cnt), 32'd0);
        check("t5_no_fe_yet", 32'(fe_cnt), 32'd0);
        check("t5_no_err", 32'(err_cnt), 32'd0);
        check("t5_frame_num_kept", 32'(bus.frame_num_o), 32'd1);
        drive(1'b1, 32'h0000_0001);
        drive(1'b0, 32'h0);
        drive(1'b0, 32'h0);
        check("t5_fe_pulses", 32'(fe_cnt), 32'd1);
        check("t5_line_count", 32'(bus.line_count_o), 32'd3);

        // 6: full frame of 10 lines, then reset mid-line
        clear_counts();
        drive(1'b1, 32'h0000_0700);
        drive(1'b0, 32'h0);
        for (int l = 0; l < 10; l++) send_line(16);
        drive(1'b1, 32'h0000_0001);
        drive(1'b0, 32'h0);
        drive(1'b0, 32'h0);
        check("t6_fs_pulses", 32'(fs_cnt), 32'd1);
        check("t6_fe_pulses", 32'(fe_cnt), 32'd1);
        check("t6_frame_num", 32'(bus.frame_num_o), 32'd7);
        check("t6_line_count", 32'(bus.line_count_o), 32'd10);
        check("t6_last_cnt", 32'(last_cnt), 32'd10);
        drive(1'b1, 32'h0009_602B);
        send_payload(2400, 5);
        reset_in = 1'b0;
        #1;
        check("t6_rst_valid", 32'(bus.payload_valid_o), 32'd0);
        check("t6_rst_lsync", 32'(bus.lsync_o), 32'd0);
        check("t6_rst_line_count", 32'(bus.line_count_o), 32'd0);
        check("t6_rst_frame_num", 32'(bus.frame_num_o), 32'd0);
        check("t6_rst_be", 32'(bus.payload_be_o), 32'd0);
        sb.delete();
        bus.data_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        reset_in = 1'b1;
        drive(1'b0, 32'h0);
        clear_counts();
        send_line(6);
        drive(1'b0, 32'h0);
        check("t6_post_err", 32'(err_cnt), 32'd0);
        check("t6_post_valid", 32'(valid_cnt), 32'd2);
        check("t6_post_line_count", 32'(bus.line_count_o), 32'd1);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
